// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the framed SIPO receiver.
// State encoding; 2'd3 is unused and recovers to ST_IDLE.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in/parallel-out shift register with enable.
// New bits enter at the MSB; the first bit ends in q[0].
module sipo_shift_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // shift toward the LSB when enabled, clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {d, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start opens a frame, WIDTH shifts fill it,
// the word is held until the consumer accepts it.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overrun;
  logic             w_shift_en;

  // state, bit counter and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            if (start) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (start) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_shift_en = (r_state == ST_SHIFT);
  assign busy       = w_shift_en;
  assign valid      = (r_state == ST_HOLD);
  assign overrun    = r_overrun;

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .en  (w_shift_en),
    .d   (din),
    .q   (data_out)
  );

endmodule
